// File: rtl/detector_scheduler_pkg.sv
// Shared types and constants for the detector scheduler.
package detector_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_SETTLE = 3'd3,
    S_REPORT = 3'd4
  } sched_state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/detector_scheduler_if.sv
// Requester and detector signals of the detector scheduler.
// slave: the scheduler; master: requesters plus the serial detector.
interface detector_scheduler_if #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic                  req0;
  logic [WORD_WIDTH-1:0] data0;
  logic                  gnt0;
  logic                  done0;
  logic                  req1;
  logic [WORD_WIDTH-1:0] data1;
  logic                  gnt1;
  logic                  done1;
  logic [CNT_WIDTH-1:0]  count;
  logic                  busy;
  logic                  det_x;
  logic                  det_reset;
  logic                  det_y;

  modport master (
    output req0, data0, req1, data1, det_y,
    input  gnt0, done0, gnt1, done1, count, busy, det_x, det_reset
  );

  modport slave (
    input  req0, data0, req1, data1, det_y,
    output gnt0, done0, gnt1, done1, count, busy, det_x, det_reset
  );
endinterface

// File: rtl/detector_scheduler_arb.sv
// Two-way arbiter for the detector scheduler.
// Round-robin on ties by default; with SCHED_FIXED_PRIORITY_EN defined requester 0
// always wins a tie and no history is kept.
module sched_rr_arbiter
  import detector_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,   // a grant is actually issued this cycle
  output logic valid,
  output logic id
);

`ifdef SCHED_FIXED_PRIORITY_EN
  // Fixed priority: requester 0 first.
  always_comb begin
    valid = req0 | req1;
    id    = req0 ? REQ_ID0 : REQ_ID1;
  end
`else
  logic last_q, last_d;

  // Pick the requester that did not win last time when both ask.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      id = (last_q == REQ_ID0) ? REQ_ID1 : REQ_ID0;
    end else begin
      id = req0 ? REQ_ID0 : REQ_ID1;
    end
    last_d = last_q;
    if (take && valid) begin
      last_d = id;
    end
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_ID1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/detector_scheduler.sv
// Shares one bit-serial Moore detector between two word-level requesters.
// Optional build macro: SCHED_FIXED_PRIORITY_EN (fixed priority instead of round-robin).
module detector_scheduler
  import detector_sched_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  detector_scheduler_if.slave bus
);

  localparam int unsigned            IDX_W    = $clog2(WORD_WIDTH + 1);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};

  sched_state_t          state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  owner_q, owner_d;
  logic                  y_sample;
  logic                  take;
  logic                  arb_valid;
  logic                  arb_id;

  assign take = (state_q == S_IDLE);

  sched_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .take  (take),
    .valid (arb_valid),
    .id    (arb_id)
  );

  // Job sequencing, word shifting and Y counting.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    count_d  = count_q;
    owner_d  = owner_q;
    y_sample = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          word_d  = (arb_id == REQ_ID1) ? bus.data1 : bus.data0;
          owner_d = arb_id;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        idx_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Y lags X by one edge, so bit 0 has no Y of its own yet.
        y_sample = (idx_q != '0) && bus.det_y;
        word_d   = word_q << 1;
        if (idx_q == LAST_IDX) begin
          state_d = S_SETTLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SETTLE: begin
        y_sample = bus.det_y;
        state_d  = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (y_sample && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Scheduler state; a reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      owner_q <= REQ_ID0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      owner_q <= owner_d;
    end
  end

  // Outputs; grants and detector release are masked while reset is asserted.
  always_comb begin
    bus.gnt0      = rst_n && take && arb_valid && (arb_id == REQ_ID0);
    bus.gnt1      = rst_n && take && arb_valid && (arb_id == REQ_ID1);
    bus.done0     = (state_q == S_REPORT) && (owner_q == REQ_ID0);
    bus.done1     = (state_q == S_REPORT) && (owner_q == REQ_ID1);
    bus.busy      = (state_q != S_IDLE);
    bus.det_x     = (state_q == S_SHIFT) && word_q[WORD_WIDTH-1];
    bus.det_reset = rst_n && (state_q != S_CLEAR);
    bus.count     = count_q;
  end

endmodule
